// File: rtl/bisr_pkg.sv
// Shared types and constants for the BIST self-repair controller.
// Used by the controller, its tag CAM and its interface.
package bisr_pkg;

  localparam int ADDR_W        = 16;
  localparam int DATA_W        = 8;
  localparam int NUM_SPARE_DEF = 4;
  localparam int IDX_W_DEF     = 2;

  // One-hot controller states
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_COLLECT = 4'b0010,
    ST_REPAIR  = 4'b0100,
    ST_FAIL    = 4'b1000
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } tag_entry_t;

endpackage

// File: rtl/bisr_repair_ctrl_if.sv
// Request/memory/BIST signal bundle for bisr_repair_ctrl.
// Handshake: REQ_VLD qualifies a request for one cycle; MEM_VLD forwards it one cycle later.
interface bisr_repair_ctrl_if
  import bisr_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
);
  logic              BIST_EN;
  logic              CLR;
  logic              FAIL_VLD;
  logic [ADDR_W-1:0] FAIL_ADDR;
  logic              REQ_VLD;
  logic              REQ_WEB;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [DATA_W-1:0] REQ_IDATA;
  logic [DATA_W-1:0] MEM_ODATA;
  logic              MEM_VLD;
  logic              MEM_WEB;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_IDATA;
  logic [DATA_W-1:0] REQ_ODATA;
  logic              SPARE_HIT;
  logic [IDX_W:0]    REPAIR_CNT;
  logic              REPAIR_FAIL;
  state_t            STATE;

  modport master (
    output BIST_EN, CLR, FAIL_VLD, FAIL_ADDR, REQ_VLD, REQ_WEB, REQ_ADDR, REQ_IDATA, MEM_ODATA,
    input  MEM_VLD, MEM_WEB, MEM_ADDR, MEM_IDATA, REQ_ODATA, SPARE_HIT, REPAIR_CNT,
           REPAIR_FAIL, STATE
  );

  modport slave (
    input  BIST_EN, CLR, FAIL_VLD, FAIL_ADDR, REQ_VLD, REQ_WEB, REQ_ADDR, REQ_IDATA, MEM_ODATA,
    output MEM_VLD, MEM_WEB, MEM_ADDR, MEM_IDATA, REQ_ODATA, SPARE_HIT, REPAIR_CNT,
           REPAIR_FAIL, STATE
  );
endinterface

// File: rtl/bisr_tag_cam.sv
// Spare tag table: parallel compare for fail capture and host remap,
// lowest-free-entry allocation and valid-entry count.
module bisr_tag_cam
  import bisr_pkg::*;
#(
  parameter int NUM_SPARE = NUM_SPARE_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] fail_addr,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              fail_hit,
  output logic              req_hit,
  output logic [IDX_W-1:0]  req_idx,
  output logic              free_vld,
  output logic [IDX_W-1:0]  free_idx,
  output logic [IDX_W:0]    cnt
);

  tag_entry_t tags [NUM_SPARE];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NUM_SPARE; i++) tags[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_SPARE; i++) tags[i] <= '0;
    end else if (wr_en && free_vld) begin
      tags[free_idx] <= '{valid: 1'b1, addr: fail_addr};
    end
  end

  // Scan high-to-low so the last assignment wins with the lowest index.
  always_comb begin
    fail_hit = 1'b0;
    req_hit  = 1'b0;
    req_idx  = '0;
    free_vld = 1'b0;
    free_idx = '0;
    cnt      = '0;
    for (int i = NUM_SPARE - 1; i >= 0; i--) begin
      if (tags[i].valid && tags[i].addr == fail_addr) fail_hit = 1'b1;
      if (tags[i].valid && tags[i].addr == req_addr) begin
        req_hit = 1'b1;
        req_idx = IDX_W'(i);
      end
      if (!tags[i].valid) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (tags[i].valid) cnt = cnt + (IDX_W + 1)'(1);
    end
  end

endmodule

// File: rtl/bisr_repair_ctrl.sv
// BIST fail collector and spare-register remapper sitting between the
// memory controller request port and the block-register memory array.
module bisr_repair_ctrl
  import bisr_pkg::*;
#(
  parameter int NUM_SPARE = NUM_SPARE_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input logic               CLK,
  input logic               RSTN,
  bisr_repair_ctrl_if.slave bus
);

  state_t            state;
  logic              repair_fail;
  logic              fail_hit, req_hit, free_vld;
  logic [IDX_W-1:0]  req_idx, free_idx, idx_q;
  logic [IDX_W:0]    cnt;
  logic [DATA_W-1:0] spare [NUM_SPARE];
  logic              new_fail, capture, overflow, remap, hit, hit_q;

  assign new_fail = (state == ST_COLLECT) && bus.FAIL_VLD && !fail_hit && !bus.CLR;
  assign capture  = new_fail && free_vld;
  assign overflow = new_fail && !free_vld;
  // BIST must see the raw array, so remap only after collection finished.
  assign remap    = (state == ST_REPAIR) || (state == ST_FAIL);
  assign hit      = remap && bus.REQ_VLD && req_hit;

  bisr_tag_cam #(.NUM_SPARE(NUM_SPARE), .IDX_W(IDX_W)) u_cam (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .clr       (bus.CLR),
    .wr_en     (capture),
    .fail_addr (bus.FAIL_ADDR),
    .req_addr  (bus.REQ_ADDR),
    .fail_hit  (fail_hit),
    .req_hit   (req_hit),
    .req_idx   (req_idx),
    .free_vld  (free_vld),
    .free_idx  (free_idx),
    .cnt       (cnt)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= ST_IDLE;
      repair_fail <= 1'b0;
    end else if (bus.CLR) begin
      state       <= ST_IDLE;
      repair_fail <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:    if (bus.BIST_EN) state <= ST_COLLECT;
        ST_COLLECT: begin
          if (overflow) begin
            state       <= ST_FAIL;
            repair_fail <= 1'b1;
          end else if (!bus.BIST_EN) begin
            state <= (cnt != '0 || capture) ? ST_REPAIR : ST_IDLE;
          end
        end
        ST_REPAIR:  if (bus.BIST_EN) state <= ST_COLLECT;
        ST_FAIL:    state <= ST_FAIL;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      bus.MEM_VLD   <= 1'b0;
      bus.MEM_WEB   <= 1'b1;
      bus.MEM_ADDR  <= '0;
      bus.MEM_IDATA <= '0;
      hit_q         <= 1'b0;
      idx_q         <= '0;
    end else begin
      bus.MEM_VLD <= bus.REQ_VLD && !hit;
      bus.MEM_WEB <= (bus.REQ_VLD && !hit) ? bus.REQ_WEB : 1'b1;
      hit_q       <= hit;
      idx_q       <= req_idx;
      if (bus.REQ_VLD) begin
        bus.MEM_ADDR  <= bus.REQ_ADDR;
        bus.MEM_IDATA <= bus.REQ_IDATA;
      end
    end
  end

  // Spare write lands on the request edge, so a following read sees it.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NUM_SPARE; i++) spare[i] <= '0;
    end else if (bus.CLR) begin
      for (int i = 0; i < NUM_SPARE; i++) spare[i] <= '0;
    end else if (hit && !bus.REQ_WEB) begin
      spare[req_idx] <= bus.REQ_IDATA;
    end
  end

  assign bus.SPARE_HIT   = hit_q;
  assign bus.REQ_ODATA   = hit_q ? spare[idx_q] : bus.MEM_ODATA;
  assign bus.REPAIR_CNT  = cnt;
  assign bus.REPAIR_FAIL = repair_fail;
  assign bus.STATE       = state;

endmodule

// File: tb/tb_bisr_repair_ctrl.sv
// Self-checking bench for bisr_repair_ctrl: fail capture, remap, overflow, clear, reset.
module tb_bisr_repair_ctrl;
  import bisr_pkg::*;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  bisr_repair_ctrl_if bus ();

  bisr_repair_ctrl dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  typedef struct packed {
    logic        web;
    logic [15:0] addr;
    logic [7:0]  idata;
    logic [7:0]  mo;
    logic        exp_vld;
    logic        exp_hit;
    logic [7:0]  exp_odata;
  } vec_t;

  typedef struct packed {
    logic [7:0]  mo;
    logic        mem_vld;
    logic        mem_web;
    logic [15:0] mem_addr;
    logic [7:0]  mem_idata;
    logic        spare_hit;
    logic [7:0]  odata;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic web, input logic [15:0] addr, input logic [7:0] idata,
                               input logic [7:0] mo, input logic vld, input logic hit,
                               input logic [7:0] od);
    vec_t v;
    v = '{web: web, addr: addr, idata: idata, mo: mo, exp_vld: vld, exp_hit: hit, exp_odata: od};
    return v;
  endfunction

  // One cycle: check the previous request's results, then drive the next request.
  task automatic step(input logic vld, input logic web, input logic [15:0] addr,
                      input logic [7:0] idata, input exp_t e);
    exp_t x;
    @(negedge CLK);
    if (exp_q.size() > 0) begin
      x = exp_t'(exp_q.pop_front());
      bus.MEM_ODATA = x.mo;
      #1;
      chk("mem_vld",   32'(bus.MEM_VLD),   32'(x.mem_vld));
      chk("mem_web",   32'(bus.MEM_WEB),   32'(x.mem_web));
      chk("mem_addr",  32'(bus.MEM_ADDR),  32'(x.mem_addr));
      chk("mem_idata", 32'(bus.MEM_IDATA), 32'(x.mem_idata));
      chk("spare_hit", 32'(bus.SPARE_HIT), 32'(x.spare_hit));
      chk("req_odata", 32'(bus.REQ_ODATA), 32'(x.odata));
    end
    bus.REQ_VLD   = vld;
    bus.REQ_WEB   = web;
    bus.REQ_ADDR  = addr;
    bus.REQ_IDATA = idata;
    if (vld) exp_q.push_back(EXP_W'(e));
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    e.mo        = v.mo;
    e.mem_vld   = v.exp_vld;
    e.mem_web   = v.exp_vld ? v.web : 1'b1;
    e.mem_addr  = v.addr;
    e.mem_idata = v.idata;
    e.spare_hit = v.exp_hit;
    e.odata     = v.exp_odata;
    step(1'b1, v.web, v.addr, v.idata, e);
  endtask

  task automatic flush();
    step(1'b0, 1'b1, 16'h0, 8'h0, '0);
  endtask

  task automatic fail(input logic [15:0] a, input logic c);
    @(negedge CLK);
    bus.FAIL_VLD  = 1'b1;
    bus.FAIL_ADDR = a;
    bus.CLR       = c;
    @(negedge CLK);
    bus.FAIL_VLD  = 1'b0;
    bus.CLR       = 1'b0;
    #1;
  endtask

  task automatic chk_status(input string tag, input state_t st, input int cnt, input logic rf);
    chk({tag, "_state"}, 32'(bus.STATE), 32'(st));
    chk({tag, "_cnt"},   32'(bus.REPAIR_CNT), 32'(cnt));
    chk({tag, "_rfail"}, 32'(bus.REPAIR_FAIL), 32'(rf));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_vld"},   32'(bus.MEM_VLD),   32'd0);
    chk({tag, "_mem_web"},   32'(bus.MEM_WEB),   32'd1);
    chk({tag, "_mem_addr"},  32'(bus.MEM_ADDR),  32'd0);
    chk({tag, "_mem_idata"}, 32'(bus.MEM_IDATA), 32'd0);
    chk({tag, "_spare_hit"}, 32'(bus.SPARE_HIT), 32'd0);
    chk({tag, "_req_odata"}, 32'(bus.REQ_ODATA), 32'd0);
    chk_status(tag, ST_IDLE, 0, 1'b0);
  endtask

  vec_t tbl_repair [7];
  vec_t tbl_fail   [6];
  logic [7:0] r1, r2;

  initial begin
    r1 = 8'($urandom_range(1, 255));
    r2 = 8'($urandom_range(1, 255));
    tbl_repair[0] = mkv(1'b0, 16'h0403, 8'hA5, 8'h11, 1'b0, 1'b1, 8'hA5);
    tbl_repair[1] = mkv(1'b1, 16'h0403, 8'h00, 8'h22, 1'b0, 1'b1, 8'hA5);
    tbl_repair[2] = mkv(1'b1, 16'h0404, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h3C);
    tbl_repair[3] = mkv(1'b0, 16'h8001, r1,    8'h44, 1'b0, 1'b1, r1);
    tbl_repair[4] = mkv(1'b1, 16'h8001, 8'h00, 8'h55, 1'b0, 1'b1, r1);
    tbl_repair[5] = mkv(1'b0, 16'h1234, 8'h5A, 8'h77, 1'b1, 1'b0, 8'h77);
    tbl_repair[6] = mkv(1'b1, 16'h0403, 8'h00, 8'h66, 1'b0, 1'b1, 8'hA5);
    tbl_fail[0]   = mkv(1'b1, 16'h0403, 8'h00, 8'h12, 1'b0, 1'b1, 8'hA5);
    tbl_fail[1]   = mkv(1'b1, 16'h8001, 8'h00, 8'h34, 1'b0, 1'b1, r1);
    tbl_fail[2]   = mkv(1'b0, 16'h0001, r2,    8'h56, 1'b0, 1'b1, r2);
    tbl_fail[3]   = mkv(1'b1, 16'h0001, 8'h00, 8'h78, 1'b0, 1'b1, r2);
    tbl_fail[4]   = mkv(1'b1, 16'h0002, 8'h00, 8'h9A, 1'b0, 1'b1, 8'h00);
    tbl_fail[5]   = mkv(1'b1, 16'h0003, 8'h00, 8'hC3, 1'b1, 1'b0, 8'hC3);

    bus.BIST_EN = 1'b0; bus.CLR = 1'b0; bus.FAIL_VLD = 1'b0; bus.FAIL_ADDR = '0;
    bus.REQ_VLD = 1'b0; bus.REQ_WEB = 1'b1; bus.REQ_ADDR = '0; bus.REQ_IDATA = '0;
    bus.MEM_ODATA = '0;

    // T1: reset values, then collect with a duplicate
    repeat (2) @(negedge CLK);
    #1;
    chk_reset_outputs("rst");
    RSTN = 1'b1;
    @(negedge CLK);
    bus.BIST_EN = 1'b1;
    @(negedge CLK); #1;
    chk("t1_collect", 32'(bus.STATE), 32'(ST_COLLECT));
    fail(16'h0403, 1'b0);
    fail(16'h0403, 1'b0);
    fail(16'h8001, 1'b0);
    chk_status("t1", ST_COLLECT, 2, 1'b0);

    // T2/T3: remap active in REPAIR
    @(negedge CLK);
    bus.BIST_EN = 1'b0;
    @(negedge CLK); #1;
    chk_status("t2", ST_REPAIR, 2, 1'b0);
    for (int i = 0; i < 7; i++) run_vec(tbl_repair[i]);
    flush();

    // T4: back to COLLECT (pass-through), then overflow
    @(negedge CLK);
    bus.BIST_EN = 1'b1;
    @(negedge CLK); #1;
    chk_status("t4a", ST_COLLECT, 2, 1'b0);
    run_vec(mkv(1'b1, 16'h0403, 8'h00, 8'h5E, 1'b1, 1'b0, 8'h5E));
    flush();
    fail(16'h0001, 1'b0);
    fail(16'h0002, 1'b0);
    chk_status("t4b", ST_COLLECT, 4, 1'b0);
    fail(16'h0001, 1'b0);
    chk_status("t4dup", ST_COLLECT, 4, 1'b0);
    fail(16'h0003, 1'b0);
    chk_status("t4ovf", ST_FAIL, 4, 1'b1);
    @(negedge CLK);
    bus.BIST_EN = 1'b0;
    for (int i = 0; i < 6; i++) run_vec(tbl_fail[i]);
    flush();
    #1;
    chk_status("t4hold", ST_FAIL, 4, 1'b1);

    // T5: CLR beats a coincident fail, from FAIL and from COLLECT
    fail(16'h0005, 1'b1);
    chk_status("t5", ST_IDLE, 0, 1'b0);
    @(negedge CLK);
    bus.BIST_EN = 1'b1;
    @(negedge CLK); #1;
    chk("t5_collect", 32'(bus.STATE), 32'(ST_COLLECT));
    fail(16'h0006, 1'b1);
    chk_status("t5clr", ST_IDLE, 0, 1'b0);
    bus.BIST_EN = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    fail(16'h0700, 1'b0);
    chk_status("t5idle", ST_IDLE, 0, 1'b0);
    run_vec(mkv(1'b1, 16'h0403, 8'h00, 8'h4B, 1'b1, 1'b0, 8'h4B));
    flush();

    // T6: reset while a spare read hit is in flight
    @(negedge CLK);
    bus.BIST_EN = 1'b1;
    @(negedge CLK);
    fail(16'h0403, 1'b0);
    bus.BIST_EN = 1'b0;
    @(negedge CLK); #1;
    chk_status("t6", ST_REPAIR, 1, 1'b0);
    run_vec(mkv(1'b0, 16'h0403, 8'h99, 8'h00, 1'b0, 1'b1, 8'h99));
    run_vec(mkv(1'b1, 16'h0403, 8'h00, 8'h00, 1'b0, 1'b1, 8'h99));
    @(negedge CLK);
    exp_q.delete();
    bus.MEM_ODATA = 8'h00;
    #1;
    chk("t6_hit_before_rst", 32'(bus.SPARE_HIT), 32'd1);
    RSTN = 1'b0;
    bus.REQ_VLD = 1'b0;
    #1;
    chk_reset_outputs("t6rst");
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK); #1;
    chk_status("t6post", ST_IDLE, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
